// File: rtl/train_motion_sequencer.sv
// Train motion sequencer.
// Initiator on the countdown-timer interface: every timed phase loads its
// duration with a one-cycle strobe and waits for a fresh tmr_done. The state
// code is published on present_state. Motor, door and alarm drives are Moore
// outputs, registered together with the state.
module train_motion_sequencer #(
  parameter int unsigned   TW      = 19,
  parameter logic [TW-1:0] T_ALARM = 19'd50000,
  parameter logic [TW-1:0] T_ACCEL = 19'd200000,
  parameter logic [TW-1:0] T_BRAKE = 19'd150000,
  parameter logic [TW-1:0] T_DOOR  = 19'd40000,
  parameter logic [TW-1:0] T_DWELL = 19'd100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          station_sensor,
  input  logic          door_closed,
  input  logic          obstacle,
  input  logic          emergency,
  input  logic          tmr_done,
  output logic [TW-1:0] tmr_value,
  output logic          tmr_load,
  output logic [3:0]    present_state,
  output logic [1:0]    motor_cmd,
  output logic          doors_open,
  output logic          alarm,
  output logic [7:0]    stop_count
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_WARN       = 4'd1;
  localparam logic [3:0] S_ACCEL      = 4'd2;
  localparam logic [3:0] S_CRUISE     = 4'd3;
  localparam logic [3:0] S_BRAKE      = 4'd4;
  localparam logic [3:0] S_DOOR_OPEN  = 4'd5;
  localparam logic [3:0] S_DWELL      = 4'd6;
  localparam logic [3:0] S_DOOR_CLOSE = 4'd7;
  localparam logic [3:0] S_EMERG      = 4'd8;
  localparam logic [3:0] S_FAULT      = 4'd9;

  localparam logic [1:0] M_STOP   = 2'b00;
  localparam logic [1:0] M_ACCEL  = 2'b01;
  localparam logic [1:0] M_CRUISE = 2'b10;
  localparam logic [1:0] M_BRAKE  = 2'b11;

  typedef struct packed {
    logic [1:0] motor;
    logic       doors;
    logic       alarm;
  } drive_t;

  logic [3:0]    state, state_next;
  logic          armed, expired, load_next, stop_inc;
  logic [TW-1:0] dur_cur, dur_next;
  drive_t        drv, drv_next;

  // States that own a timer interval.
  function automatic logic is_timed(input logic [3:0] s);
    case (s)
      S_WARN, S_ACCEL, S_BRAKE, S_DOOR_OPEN,
      S_DWELL, S_DOOR_CLOSE, S_EMERG: is_timed = 1'b1;
      default:                        is_timed = 1'b0;
    endcase
  endfunction

  // Interval length for each timed state (door close reuses T_DOOR as its
  // timeout, emergency hold reuses T_BRAKE).
  function automatic logic [TW-1:0] duration(input logic [3:0] s);
    case (s)
      S_WARN:       duration = T_ALARM;
      S_ACCEL:      duration = T_ACCEL;
      S_BRAKE:      duration = T_BRAKE;
      S_DOOR_OPEN:  duration = T_DOOR;
      S_DWELL:      duration = T_DWELL;
      S_DOOR_CLOSE: duration = T_DOOR;
      S_EMERG:      duration = T_BRAKE;
      default:      duration = '0;
    endcase
  endfunction

  assign dur_cur  = duration(state);
  assign dur_next = duration(state_next);

  // A zero-length phase is done on its only cycle; otherwise only a done
  // seen after the timer went busy again counts, so a stale flag is ignored.
  assign expired = (is_timed(state) && (dur_cur == '0)) ? 1'b1 : (armed & tmr_done);

  // Next-state selection, one transition per clock in priority order.
  always_comb begin
    state_next = state;
    stop_inc   = 1'b0;
    if (state > S_FAULT) begin
      state_next = S_FAULT;
    end else if (emergency && (state != S_IDLE) && (state != S_EMERG) && (state != S_FAULT)) begin
      state_next = S_EMERG;
    end else begin
      case (state)
        S_IDLE:       if (start && door_closed) state_next = S_WARN;
        S_WARN:       if (expired) state_next = S_ACCEL;
        S_ACCEL:      if (expired) state_next = S_CRUISE;
        S_CRUISE:     if (station_sensor) state_next = S_BRAKE;
        S_BRAKE:      if (expired) state_next = S_DOOR_OPEN;
        S_DOOR_OPEN:  if (expired) state_next = S_DWELL;
        S_DWELL:      if (expired) state_next = S_DOOR_CLOSE;
        S_DOOR_CLOSE: begin
          if (obstacle) begin
            state_next = S_DOOR_OPEN;
          end else if (door_closed) begin
            state_next = S_WARN;
            stop_inc   = 1'b1;
          end else if (expired) begin
            state_next = S_FAULT;
          end
        end
        S_EMERG:      if (expired && !emergency) state_next = S_IDLE;
        default:      state_next = S_FAULT;
      endcase
    end
  end

  // Load strobe accompanies every entry into a timed state with a nonzero
  // interval; holding in a state never reloads.
  assign load_next = (state_next != state) && is_timed(state_next) && (dur_next != '0);

  // Moore drive decode for the state being entered.
  always_comb begin
    drv_next = '0;
    case (state_next)
      S_WARN:               drv_next.alarm = 1'b1;
      S_ACCEL:              drv_next.motor = M_ACCEL;
      S_CRUISE:             drv_next.motor = M_CRUISE;
      S_BRAKE:              drv_next.motor = M_BRAKE;
      S_DOOR_OPEN, S_DWELL: drv_next.doors = 1'b1;
      S_EMERG: begin
        drv_next.motor = M_BRAKE;
        drv_next.alarm = 1'b1;
      end
      S_FAULT:              drv_next.alarm = 1'b1;
      default:              drv_next.motor = M_STOP;
    endcase
  end

  // State and drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      drv   <= '0;
    end else begin
      state <= state_next;
      drv   <= drv_next;
    end
  end

  // Timer interface: value is held between loads, strobe lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_load  <= 1'b0;
      tmr_value <= '0;
    end else begin
      tmr_load <= load_next;
      if (load_next) tmr_value <= dur_next;
    end
  end

  // Arm once the timer reports busy after a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            armed <= 1'b0;
    else if (load_next) armed <= 1'b0;
    else if (!tmr_done) armed <= 1'b1;
  end

  // Completed station stops, wrapping at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stop_count <= 8'd0;
    else if (stop_inc) stop_count <= stop_count + 8'd1;
  end

  assign present_state = state;
  assign motor_cmd     = drv.motor;
  assign doors_open    = drv.doors;
  assign alarm         = drv.alarm;

endmodule

// File: tb/tb_train_motion_sequencer.sv
// Bench for train_motion_sequencer: two instances (dwell 3 and dwell 0) share
// one stimulus stream, each checked every cycle against a trip-level model,
// plus hand-computed expectations for the directed scenarios.
module tb_train_motion_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, station_sensor = 1'b0, door_closed = 1'b0;
  logic obstacle = 1'b0, emergency = 1'b0;
  logic ovr_en = 1'b0, ovr_val = 1'b0;

  logic        done [2];
  logic [18:0] tv   [2];
  logic        tl   [2];
  logic [3:0]  ps   [2];
  logic [1:0]  mc   [2];
  logic        dop  [2];
  logic        al   [2];
  logic [7:0]  sc   [2];

  int n_chk = 0, n_pass = 0;

  // model state: expected phase, arm flag, strobe, held value, stops; timer count
  int m_st  [2] = '{0, 0};
  bit m_arm [2] = '{0, 0};
  bit m_ld  [2] = '{0, 0};
  int m_val [2] = '{0, 0};
  int m_sc  [2] = '{0, 0};
  int cnt   [2] = '{0, 0};

  always #5 clk = ~clk;

  train_motion_sequencer #(.TW(19), .T_ALARM(19'd3), .T_ACCEL(19'd5), .T_BRAKE(19'd4),
    .T_DOOR(19'd2), .T_DWELL(19'd3)) dut0 (
    .clk(clk), .rst(rst), .start(start), .station_sensor(station_sensor),
    .door_closed(door_closed), .obstacle(obstacle), .emergency(emergency),
    .tmr_done(done[0]), .tmr_value(tv[0]), .tmr_load(tl[0]), .present_state(ps[0]),
    .motor_cmd(mc[0]), .doors_open(dop[0]), .alarm(al[0]), .stop_count(sc[0]));

  train_motion_sequencer #(.TW(19), .T_ALARM(19'd3), .T_ACCEL(19'd5), .T_BRAKE(19'd4),
    .T_DOOR(19'd2), .T_DWELL(19'd0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .station_sensor(station_sensor),
    .door_closed(door_closed), .obstacle(obstacle), .emergency(emergency),
    .tmr_done(done[1]), .tmr_value(tv[1]), .tmr_load(tl[1]), .present_state(ps[1]),
    .motor_cmd(mc[1]), .doors_open(dop[1]), .alarm(al[1]), .stop_count(sc[1]));

  assign done[0] = ovr_en ? ovr_val : (cnt[0] == 0);
  assign done[1] = ovr_en ? ovr_val : (cnt[1] == 0);

  // phase lengths as configured; -1 means the phase has no interval
  function automatic int dur(input int i, input int s);
    case (s)
      1: return 3;
      2: return 5;
      4: return 4;
      5: return 2;
      6: return (i == 0) ? 3 : 0;
      7: return 2;
      8: return 4;
      default: return -1;
    endcase
  endfunction

  // trip rules: IDLE 0, WARN 1, ACCEL 2, CRUISE 3, BRAKE 4, DOOR_OPEN 5,
  // DWELL 6, DOOR_CLOSE 7, EMERG 8, FAULT 9
  function automatic int nxt(input int i, input int s, input bit arm, input bit d);
    bit x;
    x = (dur(i, s) == 0) || (arm && d);
    if (s > 9) return 9;
    if (emergency && s != 0 && s != 8 && s != 9) return 8;
    case (s)
      0: return (start && door_closed) ? 1 : 0;
      1: return x ? 2 : 1;
      2: return x ? 3 : 2;
      3: return station_sensor ? 4 : 3;
      4: return x ? 5 : 4;
      5: return x ? 6 : 5;
      6: return x ? 7 : 6;
      7: begin
        if (obstacle) return 5;
        if (door_closed) return 1;
        return x ? 9 : 7;
      end
      8: return (x && !emergency) ? 0 : 8;
      default: return s;
    endcase
  endfunction

  // model and behavioural timer advance together
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0; m_arm[i] <= 0; m_ld[i] <= 0; m_val[i] <= 0; m_sc[i] <= 0; cnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int ns = nxt(i, m_st[i], m_arm[i], done[i]);
        automatic bit ld = (ns != m_st[i]) && (dur(i, ns) > 0);
        m_st[i]  <= ns;
        m_ld[i]  <= ld;
        if (ld) m_val[i] <= dur(i, ns);
        m_arm[i] <= ld ? 1'b0 : (!done[i] ? 1'b1 : m_arm[i]);
        if (m_st[i] == 7 && ns == 1) m_sc[i] <= (m_sc[i] + 1) % 256;
        if (tl[i]) cnt[i] <= int'(tv[i]);
        else if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int em = (m_st[i] == 4 || m_st[i] == 8) ? 3 : (m_st[i] == 2) ? 1 : (m_st[i] == 3) ? 2 : 0;
      automatic bit ed = (m_st[i] == 5 || m_st[i] == 6);
      automatic bit ea = (m_st[i] == 1 || m_st[i] == 8 || m_st[i] == 9);
      n_chk++;
      if (int'(ps[i]) == m_st[i] && tl[i] === m_ld[i] && int'(tv[i]) == m_val[i] &&
          int'(mc[i]) == em && dop[i] === ed && al[i] === ea && int'(sc[i]) == m_sc[i])
        n_pass++;
      else
        $display("FAIL model%0d @%0t: st %0d/%0d ld %b/%b val %0d/%0d mot %0d/%0d door %b/%b alm %b/%b stops %0d/%0d",
          i, $time, ps[i], m_st[i], tl[i], m_ld[i], tv[i], m_val[i], mc[i], em, dop[i], ed, al[i], ea, sc[i], m_sc[i]);
    end
  end

  // trip recorder for the nominal run (until the first stop is counted)
  bit rec = 1'b0;
  int sq0[$], sq1[$], lq0[$], lq1[$];
  int dw  [2] = '{0, 0};
  int scl [2] = '{0, 0};
  always @(negedge clk) begin
    if (rec) begin
      if (scl[0] == 0 && (sq0.size() == 0 || sq0[$] != int'(ps[0]))) sq0.push_back(int'(ps[0]));
      if (scl[1] == 0 && (sq1.size() == 0 || sq1[$] != int'(ps[1]))) sq1.push_back(int'(ps[1]));
      if (tl[0] && sc[0] == 0) lq0.push_back(int'(tv[0]));
      if (tl[1] && sc[1] == 0) lq1.push_back(int'(tv[1]));
      for (int i = 0; i < 2; i++) begin
        if (ps[i] == 4'd6 && sc[i] == 0) dw[i] <= dw[i] + 1;
        scl[i] <= int'(sc[i]);
      end
    end
  end

  int es  [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 1};
  int el0 [6] = '{3, 5, 4, 2, 3, 2};
  int el1 [5] = '{3, 5, 4, 2, 2};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_st(input int code, input int bound, input string nm);
    int k;
    k = 0;
    while (int'(ps[0]) != code && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(ps[0]), code);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    start = 1'b0; station_sensor = 1'b0; obstacle = 1'b0; emergency = 1'b0;
    door_closed = 1'b1; ovr_en = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    door_closed = 1'b1;
    rec = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_state%0d", i), int'(ps[i]), 0);
      chk($sformatf("rst_load%0d", i), int'(tl[i]), 0);
      chk($sformatf("rst_value%0d", i), int'(tv[i]), 0);
      chk($sformatf("rst_drive%0d", i), int'({mc[i], dop[i], al[i]}), 0);
      chk($sformatf("rst_stops%0d", i), int'(sc[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // nominal trip
    start = 1'b1;
    wait_st(3, 40, "nom_reach_cruise");
    station_sensor = 1'b1;
    cyc(1);
    station_sensor = 1'b0;
    for (int k = 0; k < 60 && sc[0] != 8'd1; k++) @(negedge clk);
    cyc(1);
    rec = 1'b0;
    start = 1'b0;
    chk("nom_stops0", int'(sc[0]), 1);
    chk("nom_stops1", int'(sc[1]), 1);
    chk("nom_seq0_len", sq0.size(), 9);
    chk("nom_seq1_len", sq1.size(), 9);
    for (int k = 0; k < 9 && k < sq0.size(); k++) chk($sformatf("nom_seq0[%0d]", k), sq0[k], es[k]);
    for (int k = 0; k < 9 && k < sq1.size(); k++) chk($sformatf("nom_seq1[%0d]", k), sq1[k], es[k]);
    chk("nom_loads0_len", lq0.size(), 6);
    chk("nom_loads1_len", lq1.size(), 5);
    for (int k = 0; k < 6 && k < lq0.size(); k++) chk($sformatf("nom_load0[%0d]", k), lq0[k], el0[k]);
    for (int k = 0; k < 5 && k < lq1.size(); k++) chk($sformatf("nom_load1[%0d]", k), lq1[k], el1[k]);
    chk("dwell_cycles0", dw[0], 5);
    chk("dwell_cycles1_zero_dur", dw[1], 1);

    // stale done held across WARN entry
    do_reset();
    ovr_en = 1'b1; ovr_val = 1'b1; start = 1'b1;
    wait_st(1, 10, "stale_enter_warn");
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk($sformatf("stale_hold%0d", k), int'(ps[0]), 1);
    end
    ovr_val = 1'b0;
    cyc(1);
    chk("stale_busy_hold", int'(ps[0]), 1);
    ovr_val = 1'b1;
    cyc(1);
    chk("stale_fresh_done", int'(ps[0]), 2);
    ovr_en = 1'b0;

    // emergency in cruise
    do_reset();
    start = 1'b1;
    wait_st(3, 40, "em_reach_cruise");
    start = 1'b0;
    emergency = 1'b1;
    cyc(1);
    chk("em_state", int'(ps[0]), 8);
    chk("em_motor", int'(mc[0]), 3);
    chk("em_alarm", int'(al[0]), 1);
    chk("em_value", int'(tv[0]), 4);
    chk("em_load", int'(tl[0]), 1);
    cyc(12);
    chk("em_hold_state", int'(ps[0]), 8);
    chk("em_hold_noload", int'(tl[0]), 0);
    emergency = 1'b0;
    cyc(1);
    chk("em_release_idle", int'(ps[0]), 0);

    // obstacle at door close, then timeout to FAULT
    do_reset();
    start = 1'b1;
    wait_st(3, 40, "obs_reach_cruise");
    start = 1'b0;
    station_sensor = 1'b1;
    cyc(1);
    station_sensor = 1'b0;
    wait_st(6, 40, "obs_reach_dwell");
    door_closed = 1'b0;
    wait_st(7, 20, "obs_reach_close");
    obstacle = 1'b1;
    cyc(1);
    obstacle = 1'b0;
    chk("obs_reopen", int'(ps[0]), 5);
    chk("obs_reload", int'(tl[0]), 1);
    chk("obs_value", int'(tv[0]), 2);
    wait_st(9, 60, "obs_fault");
    chk("fault_alarm", int'(al[0]), 1);
    door_closed = 1'b1; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk($sformatf("fault_hold%0d", k), int'(ps[0]), 9);
    end

    // stop counter wrap
    do_reset();
    start = 1'b1; station_sensor = 1'b1;
    for (int k = 0; k < 10200 && sc[0] != 8'd255; k++) @(negedge clk);
    chk("wrap_255", int'(sc[0]), 255);
    wait_st(7, 60, "wrap_close");
    cyc(1);
    chk("wrap_state", int'(ps[0]), 1);
    chk("wrap_zero", int'(sc[0]), 0);

    // reset mid-acceleration
    do_reset();
    start = 1'b1;
    wait_st(2, 20, "rst_reach_accel");
    start = 1'b0;
    cyc(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", int'(ps[0]), 0);
    chk("midrst_load", int'(tl[0]), 0);
    chk("midrst_value", int'(tv[0]), 0);
    chk("midrst_motor", int'(mc[0]), 0);
    chk("midrst_alarm_door", int'({dop[0], al[0]}), 0);
    cyc(2);
    chk("midrst_load_during", int'(tl[0]), 0);
    rst = 1'b0;
    cyc(1);
    chk("midrst_load_after", int'(tl[0]), 0);
    chk("midrst_idle_after", int'(ps[0]), 0);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/train_motion_sequencer.md
Name: train_motion_sequencer

Overview:
- Train controller FSM that acts as the initiator on the countdown-timer interface.
- Loads a 19-bit duration with a one-cycle strobe, waits for the timer's done flag, and sequences the train through the phases departure warning, acceleration, cruise, braking, doors and dwell.
- Publishes its 4-bit state code on the shared present_state bus and drives the motor, door and alarm outputs.

Parameters:
- TW, 19, timer duration width; must match the timer's load width.
- T_ALARM, 19'd50000, departure-warning duration in clk cycles.
- T_ACCEL, 19'd200000, acceleration phase duration.
- T_BRAKE, 19'd150000, braking phase duration; also used for the emergency hold.
- T_DOOR, 19'd40000, door-open duration; also the door-close timeout.
- T_DWELL, 19'd100000, station dwell duration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; request departure from IDLE.
- station_sensor  in  1  level; station reached while cruising.
- door_closed  in  1  level; doors confirmed shut.
- obstacle  in  1  level; object in the doorway.
- emergency  in  1  level; emergency stop request.
- tmr_done  in  1  timer expired flag; high when the count is 0.
- tmr_value  out  TW  duration presented to the timer.
- tmr_load  out  1  one-cycle load strobe.
- present_state  out  4  current state code.
- motor_cmd  out  2  00 stop, 01 accel, 10 cruise, 11 brake.
- doors_open  out  1  door actuator command.
- alarm  out  1  departure/emergency buzzer.
- stop_count  out  8  number of completed station stops.

Behaviour:
- State codes:
  - IDLE=0, WARN=1, ACCEL=2, CRUISE=3, BRAKE=4, DOOR_OPEN=5, DWELL=6, DOOR_CLOSE=7, EMERG=8, FAULT=9.
  - Codes 10-15 are illegal and go to FAULT on the next clk.
- Reset (async): state IDLE; tmr_load=0, tmr_value=0, motor_cmd=00, doors_open=0, alarm=0, stop_count=0, armed=0. All outputs are registered.
- Timer handshake:
  - Entering any timed state (WARN, ACCEL, BRAKE, DOOR_OPEN, DWELL, DOOR_CLOSE, EMERG) registers tmr_value=duration and tmr_load=1 for exactly one cycle, coincident with the state change.
  - Internal flag armed clears on load and sets once tmr_done is sampled 0.
  - expired = armed & tmr_done. A stale done from the previous interval can never cause a transition.
- Zero duration: if the parameter is 0, the state is entered for one cycle with no load, and expired is treated as 1 on that cycle.
- Transitions (one per clk, evaluated in priority order):
  1. emergency=1 in any state except IDLE, EMERG, FAULT -> EMERG, with T_BRAKE loaded.
  2. IDLE: start=1 & door_closed=1 -> WARN.
  3. WARN: expired -> ACCEL.
  4. ACCEL: expired -> CRUISE (no load).
  5. CRUISE: station_sensor=1 -> BRAKE.
  6. BRAKE: expired -> DOOR_OPEN.
  7. DOOR_OPEN: expired -> DWELL.
  8. DWELL: expired -> DOOR_CLOSE.
  9. DOOR_CLOSE:
     - obstacle=1 -> DOOR_OPEN (reload T_DOOR); obstacle has priority over door_closed.
     - else door_closed=1 -> WARN, stop_count increments.
     - else expired -> FAULT.
  10. EMERG: expired & emergency=0 -> IDLE. While emergency stays high, hold in EMERG; no reload occurs.
  11. FAULT: exit only via rst.
- Outputs per state (Moore, registered with the state):
  - motor_cmd: 11 in BRAKE and EMERG; 01 in ACCEL; 10 in CRUISE; 00 otherwise.
  - doors_open=1 in DOOR_OPEN and DWELL only.
  - alarm=1 in WARN, EMERG and FAULT.
- stop_count wraps 255 -> 0.
- reset mid-interval aborts immediately; no load strobe is emitted during or right after reset.
- Simultaneous events:
  - emergency overrides station_sensor and expired in the same cycle.
  - start is ignored unless the state is IDLE.

Test Plan:
- Nominal trip with T_ALARM=3, T_ACCEL=5, T_BRAKE=4, T_DOOR=2, T_DWELL=3 and a behavioural timer:
  - Stimulus: start=1, door_closed=1; after CRUISE, pulse station_sensor; keep door_closed=1.
  - Required: present_state 0,1,2,3,4,5,6,7,1; tmr_load is one-cycle pulses with tmr_value 3,5,4,2,3,2; stop_count=1.
- Stale done: hold tmr_done=1 across the WARN entry -> no WARN->ACCEL transition until tmr_done has gone 0 and back to 1.
- Obstacle: obstacle=1 in DOOR_CLOSE -> DOOR_OPEN with tmr_load carrying tmr_value=2; door_closed never asserted afterwards -> FAULT (9), alarm=1, held until rst.
- Emergency in CRUISE -> next clk EMERG, motor_cmd=11, alarm=1, tmr_value=4. Holding emergency=1 after expiry keeps EMERG; releasing it returns to IDLE.
- T_DWELL=0 -> DWELL lasts exactly 1 cycle with no tmr_load.
- stop_count wrap: preload 255 via 255 trips -> 256th trip gives 0. Separately, assert rst in ACCEL -> all outputs reset at once, with no tmr_load during reset.
